// File: rtl/smg_pkg.sv
// smg_pkg: register map, control bit positions, segment table and field masks for smg_scan_axi
package smg_pkg;
  localparam int NUM_REGS   = 8;
  localparam int OFF_CTRL   = 0;
  localparam int OFF_DIV    = 1;
  localparam int OFF_NIB    = 2;
  localparam int OFF_DP     = 3;
  localparam int OFF_RAW0   = 4;
  localparam int OFF_RAW1   = 5;
  localparam int OFF_BRIGHT = 6;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_HEX   = 1;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  function automatic logic [31:0] ones(int w);
    return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
  endfunction
  // Implemented bits per word; everything outside the mask stays 0 and reads back 0
  function automatic logic [31:0] reg_mask(int i, int n, bit dim);
    return i == OFF_CTRL ? 32'h3 : i == OFF_DIV ? 32'hFFFF : i == OFF_NIB ? ones(4 * n) :
           i == OFF_DP ? ones(n) : i == OFF_RAW0 ? ones(8 * (n > 4 ? 4 : n)) :
           i == OFF_RAW1 ? ones(8 * (n > 4 ? n - 4 : 0)) :
           (i == OFF_BRIGHT && dim) ? 32'hF : 32'h0;
  endfunction
endpackage

// File: rtl/smg_scan_axi_if.sv
// smg_scan_axi_if: AXI4-Lite slave bus bundle for smg_scan_axi
interface smg_scan_axi_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;
  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RDATA,
           S_AXI_RRESP, S_AXI_RVALID
  );
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RDATA,
           S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/smg_hex7.sv
// smg_hex7: nibble to active-high {g,f,e,d,c,b,a} seven-segment pattern
module smg_hex7
  import smg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX7[nib_i];
endmodule

// File: rtl/smg_scan_axi.sv
// smg_scan_axi: AXI4-Lite multiplexed seven-segment scan driver.
// Define SMG_DIMMING_EN to enable BRIGHT-controlled PWM dimming of the digit selects.
module smg_scan_axi
  import smg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int ADDR_W       = 32,
  parameter int SCAN_DIV_RST = 50000
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  smg_scan_axi_if.slave         s_axi,
  output logic [7:0]            SMG_Data,
  output logic [NUM_DIGITS-1:0] Scan_Sig
);
`ifdef SMG_DIMMING_EN
  localparam bit DIM = 1'b1;
`else
  localparam bit DIM = 1'b0;
`endif
  w_state_e              w_q, w_d;
  r_state_e              r_q, r_d;
  logic [31:0]           reg_q [NUM_REGS];
  logic [31:0]           reg_d [NUM_REGS];
  logic [31:0]           rdata_q, rdata_d, bmask;
  logic [3:0]            wa, ra, nib;
  logic                  wr_en, rd_en, en, hex, clr, term, lit;
  logic [15:0]           div, pre_q, pre_d;
  logic [2:0]            idx_q, idx_d;
  logic [6:0]            seg7;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] sel_d;
  logic [63:0]           raw;
  assign wa  = s_axi.S_AXI_AWADDR[5:2];
  assign ra  = s_axi.S_AXI_ARADDR[5:2];
  assign en  = reg_q[OFF_CTRL][CTRL_EN];
  assign hex = reg_q[OFF_CTRL][CTRL_HEX];
  assign div = reg_q[OFF_DIV][15:0];
  assign raw = {reg_q[OFF_RAW1], reg_q[OFF_RAW0]};
  assign nib = reg_q[OFF_NIB][{idx_q, 2'b00} +: 4];
  assign s_axi.S_AXI_AWREADY = wr_en;
  assign s_axi.S_AXI_WREADY  = wr_en;
  assign s_axi.S_AXI_BVALID  = w_q == W_RESP;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = rd_en;
  assign s_axi.S_AXI_RVALID  = r_q == R_DATA;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  // Ready is combinational so handshakes vanish the instant reset asserts
  always_comb begin
    wr_en   = w_q == W_IDLE && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !S_AXI_ARESET;
    w_d     = wr_en ? W_RESP : (w_q == W_RESP && s_axi.S_AXI_BREADY) ? W_IDLE : w_q;
    rd_en   = r_q == R_IDLE && s_axi.S_AXI_ARVALID && !S_AXI_ARESET;
    r_d     = rd_en ? R_DATA : (r_q == R_DATA && s_axi.S_AXI_RREADY) ? R_IDLE : r_q;
    rdata_d = rd_en ? (ra[3] ? 32'h0 : reg_q[ra[2:0]]) : rdata_q;
    bmask   = {{8{s_axi.S_AXI_WSTRB[3]}}, {8{s_axi.S_AXI_WSTRB[2]}},
               {8{s_axi.S_AXI_WSTRB[1]}}, {8{s_axi.S_AXI_WSTRB[0]}}};
    for (int i = 0; i < NUM_REGS; i++)
      reg_d[i] = ((wr_en && wa == 4'(i)) ? ((reg_q[i] & ~bmask) | (s_axi.S_AXI_WDATA & bmask))
                                         : reg_q[i]) & reg_mask(i, NUM_DIGITS, DIM);
  end
  assign term = pre_q == ((div == 16'd0) ? 16'd0 : div - 16'd1);
  always_comb begin
    clr   = !en || (wr_en && wa == 4'(OFF_DIV));
    pre_d = (clr || term) ? 16'd0 : pre_q + 16'd1;
    idx_d = clr ? 3'd0 : !term ? idx_q : (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
  end
`ifdef SMG_DIMMING_EN
  logic [3:0] pwm_q;
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) pwm_q <= 4'd0;
    else pwm_q <= pwm_q + 4'd1;
  assign lit = pwm_q <= reg_q[OFF_BRIGHT][3:0];
`else
  assign lit = 1'b1;
`endif
  smg_hex7 u_hex7 (.nib_i(nib), .seg_o(seg7));
  // First cycle of every slot keeps all selects off so the previous digit does not ghost
  assign sel_d = (en && pre_q != 16'd0 && lit) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  assign seg_d = !en ? SEG_BLANK : hex ? ~{reg_q[OFF_DP][{2'b00, idx_q}], seg7}
                                       : ~raw[{idx_q, 3'b000} +: 8];
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) begin
      w_q      <= W_IDLE;
      r_q      <= R_IDLE;
      rdata_q  <= 32'h0;
      pre_q    <= 16'd0;
      idx_q    <= 3'd0;
      SMG_Data <= SEG_BLANK;
      Scan_Sig <= '1;
      for (int i = 0; i < NUM_REGS; i++)
        reg_q[i] <= (i == OFF_CTRL) ? 32'h2 : (i == OFF_DIV) ? (32'(SCAN_DIV_RST) & 32'hFFFF) : 32'h0;
    end else begin
      w_q      <= w_d;
      r_q      <= r_d;
      rdata_q  <= rdata_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      SMG_Data <= seg_d;
      Scan_Sig <= sel_d;
      reg_q    <= reg_d;
    end
endmodule

// File: tb/tb_smg_scan_axi.sv
// tb_smg_scan_axi: self-checking bench for smg_scan_axi (6 digits); the dimming scenario
// follows SMG_DIMMING_EN when the bundle is built with it.
module tb_smg_scan_axi;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic       clk, rst;
  logic [7:0] SMG_Data;
  logic [5:0] Scan_Sig;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] rd_q [$];
  logic [13:0] scan_q [$];

  smg_scan_axi_if #(.ADDR_W(32)) bus ();
  smg_scan_axi #(.NUM_DIGITS(6), .ADDR_W(32), .SCAN_DIV_RST(50000)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus), .SMG_Data(SMG_Data), .Scan_Sig(Scan_Sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string nm);
    int n = 0;
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    #1;
    while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY)) begin
      errors++; $display("FAIL %s aw/wready got 0 exp 1", nm);
    end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    checks++;
    if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
      errors++; $display("FAIL %s bvalid/bresp got %b/%b exp 1/00", nm, bus.S_AXI_BVALID, bus.S_AXI_BRESP);
    end
  endtask

  task automatic read_check(input logic [31:0] a, input logic [31:0] e, input string nm);
    int n = 0;
    logic [31:0] exp;
    rd_q.push_back(e);
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
    #1;
    while (!bus.S_AXI_ARREADY && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 50) begin @(posedge clk); #1; n++; end
    exp = rd_q.pop_front();
    checks++;
    if (bus.S_AXI_RVALID !== 1'b1) begin
      errors++; $display("FAIL %s rvalid got 0 exp 1", nm);
    end else if (bus.S_AXI_RDATA !== exp || bus.S_AXI_RRESP !== 2'b00) begin
      errors++; $display("FAIL %s rdata/rresp got %h/%b exp %h/00", nm, bus.S_AXI_RDATA, bus.S_AXI_RRESP, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_scan(input int cycles, input string nm);
    logic [13:0] exp;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk); #1;
      exp = scan_q.pop_front();
      checks++;
      if ({Scan_Sig, SMG_Data} !== exp) begin
        errors++;
        $display("FAIL %s k=%0d sel/seg got %h/%h exp %h/%h", nm, k, Scan_Sig, SMG_Data, exp[13:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (SMG_Data !== 8'hFF || Scan_Sig !== 6'h3F) begin
      errors++; $display("FAIL reset_outputs got %h/%h exp ff/3f", SMG_Data, Scan_Sig);
    end
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0) begin
      errors++; $display("FAIL reset_handshakes got %b exp 00000",
        {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    read_check(32'h00, 32'h2, "rst_ctrl");
    read_check(32'h04, 32'd50000, "rst_div");
    read_check(32'h08, 32'h0, "rst_nib");
    checks++;
    if (SMG_Data !== 8'hFF || Scan_Sig !== 6'h3F) begin
      errors++; $display("FAIL idle_outputs got %h/%h exp ff/3f", SMG_Data, Scan_Sig);
    end
  endtask

  task automatic test_scan_hex();
    logic [5:0] s;
    axi_write(32'h08, 32'h0054_3210, 4'hF, "wr_nib");
    axi_write(32'h0C, 32'h20, 4'hF, "wr_dp");
    axi_write(32'h00, 32'h3, 4'hF, "wr_ctrl_hex");
    axi_write(32'h04, 32'h4, 4'hF, "wr_div4");
    for (int k = 1; k <= 48; k++) begin
      int j = k - 1;
      int d = (j / 4) % 6;
      s = 6'h3F;
      if (j % 4 != 0) s[d] = 1'b0;
      scan_q.push_back({s, ~{d == 5, HEX[d]}});
    end
    check_scan(48, "scan_hex");
  endtask

  task automatic test_scan_raw();
    logic [5:0] s;
    logic [7:0] rb [6] = '{8'h00, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h00};
    axi_write(32'h00, 32'h1, 4'hF, "wr_ctrl_raw");
    axi_write(32'h10, 32'h80FF_0000, 4'hF, "wr_raw0");
    axi_write(32'h04, 32'h4, 4'hF, "wr_div4b");
    for (int k = 1; k <= 24; k++) begin
      int j = k - 1;
      int d = (j / 4) % 6;
      s = 6'h3F;
      if (j % 4 != 0) s[d] = 1'b0;
      scan_q.push_back({s, ~rb[d]});
    end
    check_scan(24, "scan_raw");
    axi_write(32'h00, 32'h0, 4'hF, "wr_ctrl_off");
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if (SMG_Data !== 8'hFF || Scan_Sig !== 6'h3F) begin
        errors++; $display("FAIL disabled_outputs got %h/%h exp ff/3f", SMG_Data, Scan_Sig);
      end
    end
  endtask

  task automatic test_strobe_unmapped();
    axi_write(32'h08, 32'hFFFF_FFFF, 4'b0001, "wr_nib_strb");
    read_check(32'h08, 32'h0054_32FF, "nib_strb");
    read_check(32'h3C, 32'h0, "rd_unmapped");
    axi_write(32'h3C, 32'hFFFF_FFFF, 4'hF, "wr_unmapped");
    read_check(32'h1C, 32'h0, "rd_unmapped_1c");
    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, "wr_nib_all");
    read_check(32'h08, 32'h00FF_FFFF, "nib_unused_bits");
    read_check(32'h10, 32'h80FF_0000, "raw0_readback");
  endtask

  task automatic test_back_to_back();
    bus.S_AXI_BREADY = 1'b0;
    axi_write(32'h0C, 32'h15, 4'hF, "wr_bp1");
    repeat (10) begin
      @(posedge clk); #1;
      checks++;
      if (bus.S_AXI_BVALID !== 1'b1) begin
        errors++; $display("FAIL bvalid_hold got %b exp 1", bus.S_AXI_BVALID);
      end
    end
    bus.S_AXI_AWADDR = 32'h0C; bus.S_AXI_WDATA = 32'h2A; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b0) begin
        errors++; $display("FAIL awready_blocked got %b exp 0", bus.S_AXI_AWREADY);
      end
      @(posedge clk); #1;
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_BVALID !== 1'b0) begin
      errors++; $display("FAIL awready_after_b got %b/%b exp 1/0", bus.S_AXI_AWREADY, bus.S_AXI_BVALID);
    end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    @(posedge clk); #1;
    read_check(32'h0C, 32'h2A, "dp_second_write");
  endtask

  task automatic test_dimming();
`ifdef SMG_DIMMING_EN
    int lows [2] = '{0, 0};
    axi_write(32'h18, 32'h3, 4'hF, "wr_bright");
    axi_write(32'h00, 32'h3, 4'hF, "wr_ctrl_dim");
    axi_write(32'h04, 32'd64, 4'hF, "wr_div64");
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      if (k >= 2 && Scan_Sig[0] === 1'b0) lows[(k - 2) / 16]++;
    end
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (lows[b] != 4) begin errors++; $display("FAIL dim_duty win%0d got %0d exp 4", b, lows[b]); end
    end
    read_check(32'h18, 32'h3, "bright_readback");
`else
    axi_write(32'h18, 32'h3, 4'hF, "wr_bright");
    read_check(32'h18, 32'h0, "bright_absent");
`endif
  endtask

  task automatic test_reset_mid();
    bus.S_AXI_BREADY = 1'b0;
    axi_write(32'h00, 32'h3, 4'hF, "wr_pre_rst");
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_AWREADY !== 1'b0 || SMG_Data !== 8'hFF || Scan_Sig !== 6'h3F) begin
      errors++; $display("FAIL mid_reset bvalid/awready/seg/sel got %b/%b/%h/%h exp 0/0/ff/3f",
        bus.S_AXI_BVALID, bus.S_AXI_AWREADY, SMG_Data, Scan_Sig);
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    read_check(32'h00, 32'h2, "ctrl_after_mid_rst");
  endtask

  initial begin
    rst = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0;
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1; bus.S_AXI_ARADDR = '0;
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
    test_reset();
    test_scan_hex();
    test_scan_raw();
    test_strobe_unmapped();
    test_back_to_back();
    test_dimming();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
